// File: rtl/ff_addsub_serial.sv
// Limb-serial modular add/subtract over a prime field.
// Ports: clk, rst (sync, high), start, mode (0 add, 1 sub), a, b in; out, done, busy out.
module ff_addsub_serial #(
  parameter int WIDTH = 255,
  parameter logic [WIDTH-1:0] MODULUS = {WIDTH{1'b1}} - WIDTH'(18),
  parameter int LIMB = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             busy
);

  localparam int NL = (WIDTH + LIMB - 1) / LIMB;
  localparam int NW = NL * LIMB;
  localparam int CW = (NL > 1) ? $clog2(NL) : 1;
  localparam logic [CW-1:0] LAST = CW'(NL - 1);

  // The raw sum a+b needs one bit above WIDTH.
  if (NW < WIDTH + 1) begin : g_chk
    $error("ff_addsub_serial: NL*LIMB must be >= WIDTH+1");
  end

  typedef enum logic [1:0] {
    IDLE,
    PASS1,
    PASS2,
    FIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [NW-1:0] a_q;
  logic [NW-1:0] b_q;
  logic [NW-1:0] p_q;
  logic [NW-1:0] r_q;
  logic [NW-1:0] t_q;
  logic [CW-1:0] cnt;
  logic          c_q;
  logic          bw1_q;
  logic          mode_q;

  logic            last;
  logic [LIMB-1:0] x;
  logic [LIMB-1:0] y;
  logic            add;
  logic [LIMB:0]   s;
  logic            c_nxt;
  logic [NW-1:0]   ins;
  logic [NW-1:0]   r_shf;
  logic [NW-1:0]   r_rot;
  logic [NW-1:0]   t_nxt;
  logic            use_t;

  assign last = (cnt == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; FIN always returns to IDLE so a start there is dropped
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PASS1;
      PASS1:   if (last) state_nxt = PASS2;
      PASS2:   if (last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state != IDLE);
    done = (state == FIN);
  end

  // Shared limb adder: PASS1 works on a/b, PASS2 on r/P with the
  // opposite operation, so one add/sub slice serves both passes.
  always_comb begin
    if (state == PASS2) begin
      x   = r_q[LIMB-1:0];
      y   = p_q[LIMB-1:0];
      add = mode_q;
    end else begin
      x   = a_q[LIMB-1:0];
      y   = b_q[LIMB-1:0];
      add = ~mode_q;
    end
    if (add) begin
      s = {1'b0, x} + {1'b0, y} + {{LIMB{1'b0}}, c_q};
    end else begin
      s = {1'b0, x} - {1'b0, y} - {{LIMB{1'b0}}, c_q};
    end
    c_nxt = s[LIMB];
  end

  // Limb results enter at the top and drift down, so after NL steps
  // the least significant limb sits at the bottom.
  always_comb begin
    ins   = NW'(s[LIMB-1:0]) << (NW - LIMB);
    r_shf = (r_q >> LIMB) | ins;
    r_rot = (r_q >> LIMB) | (r_q << (NW - LIMB));
    t_nxt = (t_q >> LIMB) | ins;
    // add: keep r-P unless it borrowed; sub: add P back only if a<b
    use_t = mode_q ? bw1_q : ~c_nxt;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      r_q    <= '0;
      t_q    <= '0;
      cnt    <= '0;
      c_q    <= 1'b0;
      bw1_q  <= 1'b0;
      mode_q <= 1'b0;
      out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= NW'(a);
            b_q    <= NW'(b);
            p_q    <= NW'(MODULUS);
            mode_q <= mode;
            cnt    <= '0;
            c_q    <= 1'b0;
          end
        end
        PASS1: begin
          a_q <= a_q >> LIMB;
          b_q <= b_q >> LIMB;
          r_q <= r_shf;
          if (last) begin
            cnt   <= '0;
            bw1_q <= c_nxt;
            c_q   <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
            c_q <= c_nxt;
          end
        end
        PASS2: begin
          // r rotates so it is back in place after NL steps
          r_q <= r_rot;
          p_q <= p_q >> LIMB;
          t_q <= t_nxt;
          c_q <= c_nxt;
          if (last) begin
            cnt <= '0;
            if (use_t) begin
              out <= t_nxt[WIDTH-1:0];
            end else begin
              out <= r_rot[WIDTH-1:0];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ff_addsub_serial.sv
// Directed bench for ff_addsub_serial: default field and a small
// 8-bit field instance, checking results, latency and handshake.
module tb_ff_addsub_serial;

  localparam logic [254:0] P = {255{1'b1}} - 255'd18;

  logic         clk = 1'b0;
  logic         rst0, start0, mode0;
  logic [254:0] a0, b0, out0;
  logic         done0, busy0;
  logic         rst1, start1, mode1;
  logic [7:0]   a1, b1, out1;
  logic         done1, busy1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ff_addsub_serial dut0 (
    .clk(clk), .rst(rst0), .start(start0), .mode(mode0),
    .a(a0), .b(b0), .out(out0), .done(done0), .busy(busy0)
  );

  ff_addsub_serial #(
    .WIDTH(8), .MODULUS(8'd251), .LIMB(3)
  ) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .mode(mode1),
    .a(a1), .b(b1), .out(out1), .done(done1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One operation; cycle 1 is the cycle after start is sampled.
  // rp: re-pulse start in cycles 3 and 9; rc: assert rst in that cycle.
  task automatic run(input int d, input logic m,
                     input logic [254:0] x, input logic [254:0] y,
                     input int rp, input int rc,
                     output logic [254:0] res, output int lat,
                     output int nd, output int nb);
    logic dn, bz;
    lat = -1; nd = 0; nb = 0; res = '0;
    @(posedge clk); #1;
    if (d == 0) begin
      start0 = 1'b1; mode0 = m; a0 = x; b0 = y;
    end else begin
      start1 = 1'b1; mode1 = m; a1 = x[7:0]; b1 = y[7:0];
    end
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    a0 = ~x; b0 = x ^ y; mode0 = ~m;
    a1 = ~x[7:0]; b1 = x[7:0] ^ y[7:0]; mode1 = ~m;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      if (d == 0) begin
        start0 = (rp != 0) && (cyc == 3 || cyc == 9);
        rst0   = (cyc == rc);
      end else begin
        start1 = (rp != 0) && (cyc == 3 || cyc == 9);
        rst1   = (cyc == rc);
      end
      @(negedge clk);
      dn = (d == 0) ? done0 : done1;
      bz = (d == 0) ? busy0 : busy1;
      if (dn) begin
        nd++;
        if (lat < 0) begin
          lat = cyc;
          res = (d == 0) ? out0 : 255'(out1);
        end
      end
      if (bz) nb++;
      @(posedge clk); #1;
    end
    start0 = 1'b0; start1 = 1'b0; rst0 = 1'b0; rst1 = 1'b0;
  endtask

  logic [254:0] res;
  int lat, nd, nb;

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    start0 = 1'b1; start1 = 1'b1;
    mode0 = 1'b0; mode1 = 1'b0;
    a0 = 255'd5; b0 = 255'd7; a1 = 8'd1; b1 = 8'd2;
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    @(negedge clk);
    check("rst_out0", out0, 0);
    check("rst_done0", done0, 0);
    check("rst_busy0", busy0, 0);
    check("rst_out1", out1, 0);
    check("rst_busy1", busy1, 0);

    run(0, 1'b0, 255'd5, 255'd7, 0, 0, res, lat, nd, nb);
    check("add5_7", res, 12);
    check("add5_7_lat", lat, 9);
    check("add5_7_ndone", nd, 1);
    check("add5_7_busy", nb, 9);

    run(0, 1'b0, P - 255'd1, 255'd2, 0, 0, res, lat, nd, nb);
    check("addwrap", res, 1);
    run(0, 1'b0, 255'd0, 255'd0, 0, 0, res, lat, nd, nb);
    check("add0_0", res, 0);
    run(0, 1'b1, 255'd3, 255'd5, 0, 0, res, lat, nd, nb);
    check("sub3_5", res, P - 255'd2);
    check("sub3_5_lat", lat, 9);
    run(0, 1'b1, P - 255'd1, P - 255'd1, 0, 0, res, lat, nd, nb);
    check("subeq", res, 0);

    run(0, 1'b0, 255'd5, 255'd7, 1, 0, res, lat, nd, nb);
    check("rep_res", res, 12);
    check("rep_ndone", nd, 1);
    check("rep_lat", lat, 9);
    check("rep_busy", nb, 9);
    check("rep_idle", busy0, 0);

    run(0, 1'b0, 255'd5, 255'd7, 0, 4, res, lat, nd, nb);
    check("abort_ndone", nd, 0);
    check("abort_out", out0, 0);
    check("abort_busy", nb, 4);
    run(0, 1'b1, 255'd3, 255'd5, 0, 0, res, lat, nd, nb);
    check("post_rst_sub", res, P - 255'd2);
    check("post_rst_lat", lat, 9);

    a0 = 255'd99; b0 = 255'd1; mode0 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("hold_out", out0, P - 255'd2);

    run(1, 1'b0, 255'd250, 255'd250, 0, 0, res, lat, nd, nb);
    check("s_add", res, 249);
    check("s_add_lat", lat, 7);
    check("s_add_busy", nb, 7);
    run(1, 1'b1, 255'd0, 255'd1, 0, 0, res, lat, nd, nb);
    check("s_sub", res, 250);
    check("s_sub_lat", lat, 7);
    run(1, 1'b0, 255'd100, 255'd200, 0, 0, res, lat, nd, nb);
    check("s_add2", res, 49);
    run(1, 1'b1, 255'd7, 255'd3, 0, 0, res, lat, nd, nb);
    check("s_sub2", res, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
